// File: rtl/storage_arbiter.sv
// storage_arbiter: shares the single-port storage RAM between NUM_REQ burst
// requesters. It grants one requester at a time and issues one beat per cycle
// for the whole burst. Read data comes back with a per-port valid, and a
// one-cycle done pulse ends each burst.
// Optional feature: define STORAGE_ARB_RR_EN for round-robin arbitration.
// When it is undefined, fixed priority is used (port 0 highest).
module storage_arbiter #(
   parameter int unsigned NUM_REQ = 3,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ-1:0]        req_we,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0]      req_len,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        beat_ack,
   output logic [NUM_REQ-1:0]        rvalid,
   output logic [DATA_W-1:0]         rdata,
   output logic [NUM_REQ-1:0]        done,
   output logic                      busy,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StBurst = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   win_q;
   logic [ADDR_W-1:0]  base_q;
   logic [7:0]         len_q;
   logic               we_q;
   logic [7:0]         beat_q;
   logic [NUM_REQ-1:0] rvalid_q;

   logic               any_req;
   logic [IDX_W-1:0]   pick;
   logic [ADDR_W-1:0]  sel_addr;
   logic [7:0]         sel_len;
   logic               sel_we;
   logic [DATA_W-1:0]  win_wdata;
   logic [NUM_REQ-1:0] win_oh;
   logic               in_burst;

`ifdef STORAGE_ARB_RR_EN
   logic [IDX_W-1:0]   rr_ptr_q;

   // Round-robin pick: first requesting port at or after rr_ptr_q, wrapping
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      for (int unsigned off = 0; off < NUM_REQ; off++) begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!any_req && req[i] && ((32'(rr_ptr_q) + off) % NUM_REQ == i)) begin
               pick    = IDX_W'(i);
               any_req = 1'b1;
            end
         end
      end
   end

   // Pointer moves past the winner once its burst has finished
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
      end else if (state_q == StDone) begin
         if (32'(win_q) == NUM_REQ - 1) begin
            rr_ptr_q <= '0;
         end else begin
            rr_ptr_q <= win_q + IDX_W'(1);
         end
      end
   end
`else
   // Fixed priority pick: lowest-numbered requesting port wins
   always_comb begin
      pick    = '0;
      any_req = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!any_req && req[i]) begin
            pick    = IDX_W'(i);
            any_req = 1'b1;
         end
      end
   end
`endif

   // Select the burst parameters of the candidate winner and the winner's write data
   always_comb begin
      sel_addr  = '0;
      sel_len   = '0;
      sel_we    = 1'b0;
      win_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick == IDX_W'(i)) begin
            sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            sel_len  = req_len[i*8 +: 8];
            sel_we   = req_we[i];
         end
         if (win_q == IDX_W'(i)) begin
            win_wdata = req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   // One-hot form of the latched winner
   always_comb begin
      win_oh = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         win_oh[i] = (win_q == IDX_W'(i));
      end
   end

   // Burst sequencing: idle -> burst of len_eff beats -> done -> idle
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (any_req) state_d = StBurst;
         StBurst: if (beat_q == len_q - 8'd1) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State, latched burst parameters and beat counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         win_q   <= '0;
         base_q  <= '0;
         len_q   <= 8'd1;
         we_q    <= 1'b0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StIdle && any_req) begin
            win_q  <= pick;
            base_q <= sel_addr;
            len_q  <= (sel_len == 8'd0) ? 8'd1 : sel_len;
            we_q   <= sel_we;
            beat_q <= '0;
         end else if (state_q == StBurst) begin
            beat_q <= beat_q + 8'd1;
         end
      end
   end

   // Read data valid follows each read beat by the one-cycle RAM latency
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rvalid_q <= '0;
      end else begin
         rvalid_q <= (state_q == StBurst && !we_q) ? win_oh : '0;
      end
   end

   assign in_burst  = (state_q == StBurst);
   assign gnt       = in_burst ? win_oh : '0;
   assign beat_ack  = (in_burst && we_q) ? win_oh : '0;
   assign done      = (state_q == StDone) ? win_oh : '0;
   assign busy      = (state_q != StIdle);
   assign rvalid    = rvalid_q;
   // Gated so the shared read bus stays at zero outside valid read data
   assign rdata     = (|rvalid_q) ? mem_rdata : '0;
   assign mem_en    = in_burst;
   assign mem_we    = in_burst && we_q;
   assign mem_addr  = in_burst ? base_q + ADDR_W'(beat_q) : '0;
   assign mem_wdata = (in_burst && we_q) ? win_wdata : '0;

endmodule

// File: doc/storage_arbiter.md
# storage_arbiter

Shares the single-port matrix storage RAM between three burst requesters: input writer (port 0), calculator (port 1) and display reader (port 2). It grants one requester at a time and drives the RAM for a whole burst of consecutive addresses. It returns read data with a per-port valid and signals completion. It sits between the top-level FSM's subsystems and the storage RAM; address allocation stays in the FSM/MMU.

## Interface
- NUM_REQ, 3: number of requesters; port i owns slice i of every packed bus.
- ADDR_W, 8: RAM address width.
- DATA_W, 32: RAM word width.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  request; addr/len/we held stable from assertion until gnt.
- req_we  input  NUM_REQ  1 = write burst, 0 = read burst.
- req_addr  input  NUM_REQ*ADDR_W  burst base address.
- req_len  input  NUM_REQ*8  beat count; 0 is treated as 1.
- req_wdata  input  NUM_REQ*DATA_W  write data for the current beat.
- gnt  output  NUM_REQ  one-hot grant, high for the whole burst.
- beat_ack  output  NUM_REQ  write beat consumed this cycle; the requester presents the next word on the following cycle.
- rvalid  output  NUM_REQ  rdata is valid for this port.
- rdata  output  DATA_W  read data, shared by all ports.
- done  output  NUM_REQ  one-cycle pulse at the end of a burst.
- busy  output  1  state is not IDLE.
- mem_en, mem_we  output  1  RAM strobe and write enable.
- mem_addr  output  ADDR_W  RAM address.
- mem_wdata  output  DATA_W  RAM write data.
- mem_rdata  input  DATA_W  RAM read data, 1-cycle latency after mem_en.

## Operation
- States:
  - IDLE → BURST when any req bit is high.
  - BURST → DONE after the last beat is issued.
  - DONE → IDLE unconditionally.
- Arbitration in IDLE picks the winner per Configuration, then latches base, len and we, and sets the winner's gnt bit.
- BURST, one beat per cycle:
  - mem_en=1, mem_addr=base+beat. The address add wraps modulo 2^ADDR_W.
  - Write: mem_we=1, mem_wdata=req_wdata slice of the winner; beat_ack[winner]=1.
  - Read: mem_we=0; rvalid[winner] is asserted on the next cycle with rdata=mem_rdata.
- Beat counter is 8-bit and counts 0..len_eff-1, where len_eff = (len==0) ? 1 : len.
- DONE:
  - gnt=0 and done[winner]=1.
  - For reads, the last rvalid falls in this cycle.
  - The round-robin pointer is updated here.
- Deasserting req mid-burst is ignored; the burst always completes. Abort is not supported.
- A requester still holding req after done is re-arbitrated in the next IDLE cycle as a new burst.
- Simultaneous requests are resolved only in IDLE; requests arriving during BURST/DONE wait.
- Reset (asynchronous, also mid-burst):
  - All outputs go to 0, state goes to IDLE and the round-robin pointer goes to 0.
  - The partial burst is abandoned; already-written words remain in RAM.

## Timing
- req sampled high in IDLE at cycle T → gnt and the first mem_en at T+1.
- Beats issue at T+1..T+len_eff; DONE at T+len_eff+1; IDLE at T+len_eff+2.
- Read beat k (issued at T+1+k) has its rvalid at T+2+k.
- Back-to-back bursts are separated by exactly one IDLE cycle; a burst occupies len_eff+2 cycles in total.
- gnt, done, rvalid, busy and mem_* are registered or decoded from registered state only. No combinational path exists from req to any output.
- beat_ack = gnt & we & BURST, so it is decoded from registers.

## Configuration
- STORAGE_ARB_RR_EN defined:
  - Round-robin arbitration. The search starts at rr_ptr; after each burst, rr_ptr = winner+1 mod NUM_REQ.
- STORAGE_ARB_RR_EN undefined:
  - Fixed priority, with port 0 highest and port NUM_REQ-1 lowest.
  - rr_ptr is absent; starvation of lower ports is allowed.

## Test plan
- Single write: port 0, addr 0x10, len 3, data 0xA,0xB,0xC.
  - gnt0 covers T+1..T+3.
  - mem writes 0x10/0x11/0x12 with 0xA/0xB/0xC.
  - beat_ack0 at T+1..T+3, done0 at T+4.
- Read back: port 2, addr 0x10, len 3.
  - rvalid2 at T+2..T+4 with rdata 0xA,0xB,0xC.
  - done2 at T+4, coinciding with the last rvalid.
- Contention with RR enabled: ports 0, 1 and 2 request len 1 in the same cycle while continuously re-requesting.
  - Grant order is 0,1,2,0; each burst occupies 3 cycles.
  - With the macro undefined, port 0 is granted every burst.
- Wrap and zero length:
  - Port 1 writes addr 0xFE, len 3: addresses are 0xFE, 0xFF, 0x00.
  - Port 1 with len 0 produces exactly one beat.
- Mid-burst events:
  - req0 dropped at beat 1 of a len-4 write: all 4 beats still complete.
  - rst pulsed at beat 2 of a len-4 write: mem_en, gnt and busy drop immediately; the next req is granted from IDLE normally.
